instr_encoder: RTL

- Inverse of the instruction decoder: takes a one-hot mnemonic plus operand fields and produces the 8-bit instruction byte(s) the decoder consumes.
- Writes bytes sequentially into instruction RAM through a write port with an auto-incrementing address pointer.
- Used as the program loader in front of instruction memory. Jump instructions are emitted as two bytes: opcode, then target address.

---
 rtl/instr_encoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Program loader: turns a one-hot mnemonic plus operand fields into decoder
// instruction bytes and streams them into instruction RAM at an auto-incrementing pointer.
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          VALID,
    output logic          READY,
    input  logic [15:0]   OP,
    input  logic [1:0]    RD,
    input  logic [1:0]    RS,
    input  logic [7:0]    IMM,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [7:0]    MEM_DATA,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    ERR_CODE
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WR_OP  = 2'd1;
    localparam logic [1:0] S_WR_IMM = 2'd2;

    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] E_NONE   = 2'b00;
    localparam logic [1:0] E_ONEHOT = 2'b01;
    localparam logic [1:0] E_OPERND = 2'b10;
    localparam logic [1:0] E_SPACE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    imm_q, imm_d;
    logic          jump_q, jump_d;
    logic          halt_q, halt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          onehot, is_jump, illegal, no_room, accept;
    logic [AW:0]   free_bytes;
    logic [7:0]    enc;

    assign FULL     = (ptr_q == CAP);
    assign READY    = (state_q == S_IDLE) && !FULL && !done_q && !START;
    assign accept   = VALID && READY;
    assign MEM_WE   = we_q;
    assign MEM_ADDR = addr_q;
    assign MEM_DATA = data_q;
    assign COUNT    = ptr_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = code_q;

    assign onehot     = (OP != 16'd0) && ((OP & (OP - 16'd1)) == 16'd0);
    assign is_jump    = |OP[11:9];
    // MOVA/MOVB/MOVC share opcode 1100; the 11 field values are what tell them apart
    assign illegal    = (OP[0] && (RD == 2'b11 || RS == 2'b11)) ||
                        (OP[1] && RS == 2'b11) ||
                        (OP[2] && RD == 2'b11);
    assign free_bytes = CAP - ptr_q;
    assign no_room    = is_jump && (free_bytes < (AW+1)'(2));

    always_comb begin
        enc = 8'h00;
        case (1'b1)
            OP[0]:   enc = {4'b1100, RD, RS};
            OP[1]:   enc = {4'b1100, 2'b11, RS};
            OP[2]:   enc = {4'b1100, RD, 2'b11};
            OP[3]:   enc = {4'b1001, RD, RS};
            OP[4]:   enc = {4'b0110, RD, RS};
            OP[5]:   enc = {4'b1011, RD, RS};
            OP[6]:   enc = {4'b0101, RD, 2'b00};
            OP[7]:   enc = {4'b1010, RD, 2'b00};
            OP[8]:   enc = {4'b1010, RD, 2'b11};
            OP[9]:   enc = 8'h30;
            OP[10]:  enc = 8'h31;
            OP[11]:  enc = 8'h32;
            OP[12]:  enc = {4'b0010, RD, 2'b00};
            OP[13]:  enc = {4'b0100, 2'b00, RS};
            OP[14]:  enc = 8'h70;
            OP[15]:  enc = 8'h80;
            default: enc = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        imm_d   = imm_q;
        jump_d  = jump_q;
        halt_d  = halt_q;
        done_d  = done_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ptr_d  = '0;
                    done_d = 1'b0;
                    code_d = E_NONE;
                end else if (accept) begin
                    if (!onehot) begin
                        err_d  = 1'b1;
                        code_d = E_ONEHOT;
                    end else if (illegal) begin
                        err_d  = 1'b1;
                        code_d = E_OPERND;
                    end else if (no_room) begin
                        err_d  = 1'b1;
                        code_d = E_SPACE;
                    end else begin
                        code_d  = E_NONE;
                        we_d    = 1'b1;
                        addr_d  = ptr_q[AW-1:0];
                        data_d  = enc;
                        imm_d   = IMM;
                        jump_d  = is_jump;
                        halt_d  = OP[15];
                        state_d = S_WR_OP;
                    end
                end
            end
            S_WR_OP: begin
                ptr_d = ptr_q + (AW+1)'(1);
                if (halt_q) done_d = 1'b1;
                if (jump_q) begin
                    // room for both bytes was checked at accept, so this cannot wrap
                    we_d    = 1'b1;
                    addr_d  = ptr_q[AW-1:0] + AW'(1);
                    data_d  = imm_q;
                    state_d = S_WR_IMM;
                end else begin
                    we_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WR_IMM: begin
                ptr_d   = ptr_q + (AW+1)'(1);
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'h00;
            imm_q   <= 8'h00;
            jump_q  <= 1'b0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            imm_q   <= imm_d;
            jump_q  <= jump_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

endmodule
